fir_out_stage: RTL and testbench
================================

Name: fir_out_stage

Overview:
Output conditioning stage directly downstream of the FIR core, in the clk2 domain. It captures each 38-bit signed accumulator result on its single-cycle valid pulse, then applies a programmable arithmetic right shift with round-half-up. The result is saturated to 16-bit signed and buffered in a small FIFO that the consumer drains through a valid/ready handshake. Saturation and overflow-drop events are reported through sticky status.

Parameters:
ACC_W, 38, accumulator input width (signed)
OUT_W, 16, output sample width (signed)
DEPTH, 4, output FIFO depth; power of two, at least 2
SHIFT_W, 5, width of shift control; legal shift range 0..ACC_W-OUT_W

Ports:
clk2  in  1  operating clock, rising edge
rstn  in  1  reset
acc_in  in  ACC_W  signed accumulator result from the FIR core
acc_valid  in  1  one-cycle pulse; acc_in is valid this cycle
shift  in  SHIFT_W  right-shift amount; values above ACC_W-OUT_W are clamped
out_data  out  OUT_W  signed sample at the FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_data this cycle
level  out  clog2(DEPTH)+1  current FIFO occupancy
sat_flag  out  1  sticky; set when any sample saturated
drop_cnt  out  8  saturating count of samples dropped because the FIFO was full
clr_flags  in  1  synchronous clear of sat_flag and drop_cnt

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk2. While rstn=0, all outputs are 0, the FIFO is empty, and the pipeline valid bits are cleared. Reset mid-operation discards every in-flight and buffered sample.
- Stage 1 (registered on acc_valid):
  - shift is sampled in the same cycle; a later change of shift affects only later samples.
  - Computed in ACC_W+1 bits: r = (acc_in + (shift>0 ? 2^(shift-1) : 0)) >>> shift.
  - The extra bit prevents overflow from the rounding addend.
- Stage 2 (registered):
  - If r > 2^(OUT_W-1)-1, result = 2^(OUT_W-1)-1. If r < -2^(OUT_W-1), result = -2^(OUT_W-1). Otherwise result = r truncated to OUT_W.
  - Any clamp sets sat_flag.
- Push: a stage-2 valid pushes into the FIFO when not full. When full, the sample is dropped and drop_cnt increments, holding at 255.
- Pop: occurs when out_valid && out_ready. out_data is the FIFO head and is held stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - When full, the push is accepted (no drop) and level is unchanged.
  - When empty, the push is not visible until the next cycle; pop is impossible.
- Latency: acc_valid at cycle n gives out_valid=1 at n+3 when the FIFO was empty. Sustained throughput is one sample per cycle when out_ready=1.
- Status:
  - level updates in the cycle after a push or pop.
  - clr_flags clears sat_flag and drop_cnt. A set or increment event in the same cycle wins: flag=1, cnt=1.
- acc_valid on consecutive cycles is legal; no back-pressure is exerted upstream. The FIR core has no stall input, so overflow is handled by dropping and counting.
- out_data when out_valid=0 holds its last value; it is 0 after reset.

Decomposition:
- Shared package fir_pkg: ACC_W, OUT_W, OUT_MAX and OUT_MIN saturation constants, and the drop_cnt width.
- One sub-module: fir_out_fifo, a synchronous FIFO (DEPTH, OUT_W) with push, pop, full, empty, level and a registered head. Round/saturate logic stays in fir_out_stage.

Test Plan:
- Passthrough: shift=0, out_ready=1, acc_in=1000 pulse at cycle n -> out_data=1000 and out_valid=1 at n+3, level returns to 0 at n+4.
- Rounding: shift=1, acc_in=5 -> 3; acc_in=-5 -> -2; shift=4, acc_in=-24 -> -1; acc_in=23 -> 1 (output order preserved).
- Saturation: shift=0, acc_in=2^20 -> 32767 and sat_flag=1; acc_in=-2^20 -> -32768; clr_flags pulse -> sat_flag=0 next cycle.
- Overflow: out_ready=0, 6 back-to-back valids 1..6 -> level=4, drop_cnt=2; then out_ready=1 -> out_data 1,2,3,4 on consecutive cycles.
- Full with simultaneous pop: FIFO at 4, out_ready=1 in the same cycle a new sample arrives -> no drop, level stays 4, drop_cnt unchanged.
- Reset mid-stream: rstn=0 while level=3 and stage 1/2 occupied -> out_valid=0, level=0, out_data=0, flags 0; first post-reset sample emerges alone with latency 3.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR output conditioning stage.
// Widths, saturation limits and the drop counter size.
package fir_pkg;
   localparam int ACC_W = 38;
   localparam int OUT_W = 16;
   localparam int CNT_W = 8;
   localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
endpackage

// File: rtl/fir_out_stage_if.sv
// Output sample stream from the FIR output stage to its consumer.
// Valid/ready handshake, data held while valid and not ready.
interface fir_out_stage_if #(
   parameter int OUT_W = fir_pkg::OUT_W
);
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO with a registered head word.
// The head keeps its last value once the FIFO drains.
module fir_out_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk2,
   input  logic          rstn,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic [W-1:0]  head
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [AW:0]   cnt;
   logic          pop_ok;
   logic          push_ok;
   logic          one;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign one     = (cnt == (AW+1)'(1));
   assign level   = cnt;
   assign rd_nxt  = rd_ptr + AW'(1);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk2) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         head   <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_nxt;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
         // New word becomes head when it lands in an empty or draining FIFO
         if (push_ok && (empty || (pop_ok && one)))
            head <= din;
         else if (pop_ok && !one)
            head <= mem[rd_nxt];
      end
   end
endmodule

// File: rtl/fir_out_stage.sv
// FIR output conditioning: round-half-up shift, 16-bit saturate,
// small output FIFO with sticky saturation and drop status.
module fir_out_stage #(
   parameter int ACC_W = fir_pkg::ACC_W,
   parameter int OUT_W = fir_pkg::OUT_W,
   parameter int DEPTH = 4,
   parameter int SHIFT_W = 5,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic                     clk2,
   input  logic                     rstn,
   input  logic signed [ACC_W-1:0]  acc_in,
   input  logic                     acc_valid,
   input  logic [SHIFT_W-1:0]       shift,
   fir_out_stage_if.master          dn,
   output logic [LVL_W-1:0]         level,
   output logic                     sat_flag,
   output logic [fir_pkg::CNT_W-1:0] drop_cnt,
   input  logic                     clr_flags
);
   import fir_pkg::*;

   localparam int SH_MAX = ACC_W - OUT_W;
   localparam logic signed [ACC_W:0] R_MAX =
      {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] R_MIN =
      {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] O_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SHIFT_W-1:0]     sh;
   logic signed [ACC_W:0]  rnd;
   logic signed [ACC_W:0]  sum;
   logic signed [ACC_W:0]  r_d;
   logic signed [ACC_W:0]  s1_r;
   logic                   s1_v;
   logic                   s2_v;
   logic [OUT_W-1:0]       s2_d;
   logic [OUT_W-1:0]       clip;
   logic                   sat_hi;
   logic                   sat_lo;
   logic                   sat_ev;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic                   drop;

   // One guard bit above ACC_W absorbs the rounding addend
   always_comb begin
      sh = shift;
      if (shift > SHIFT_W'(SH_MAX))
         sh = SHIFT_W'(SH_MAX);
      rnd = '0;
      if (sh != '0)
         rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - SHIFT_W'(1));
      sum = $signed({acc_in[ACC_W-1], acc_in}) + rnd;
      r_d = sum >>> sh;
   end

   always_comb begin
      sat_hi = (s1_r > R_MAX);
      sat_lo = (s1_r < R_MIN);
      clip   = s1_r[OUT_W-1:0];
      unique case (1'b1)
         sat_hi:  clip = O_MAX;
         sat_lo:  clip = O_MIN;
         default: ;
      endcase
   end

   assign sat_ev       = s1_v && (sat_hi || sat_lo);
   assign pop          = !empty && dn.out_ready;
   assign drop         = s2_v && full && !pop;
   assign dn.out_valid = !empty;

   always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) begin
         s1_v <= 1'b0;
         s1_r <= '0;
         s2_v <= 1'b0;
         s2_d <= '0;
      end else begin
         s1_v <= acc_valid;
         if (acc_valid)
            s1_r <= r_d;
         s2_v <= s1_v;
         if (s1_v)
            s2_d <= clip;
      end
   end

   // Set and increment events take priority over a same-cycle clear
   always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) begin
         sat_flag <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (sat_ev)
            sat_flag <= 1'b1;
         else if (clr_flags)
            sat_flag <= 1'b0;
         if (drop) begin
            if (clr_flags)
               drop_cnt <= CNT_W'(1);
            else if (drop_cnt != CNT_MAX)
               drop_cnt <= drop_cnt + CNT_W'(1);
         end else if (clr_flags) begin
            drop_cnt <= '0;
         end
      end
   end

   fir_out_fifo #(
      .DEPTH (DEPTH),
      .W     (OUT_W)
   ) u_fifo (
      .clk2  (clk2),
      .rstn  (rstn),
      .push  (s2_v),
      .din   (s2_d),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .level (level),
      .head  (dn.out_data)
   );
endmodule

// File: tb/tb_fir_out_stage.sv
// Bench for fir_out_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_fir_out_stage;
   logic               clk2 = 1'b0;
   logic               rstn;
   logic signed [37:0] acc_in;
   logic               acc_valid;
   logic [4:0]         shift;
   logic [2:0]         level;
   logic               sat_flag;
   logic [7:0]         drop_cnt;
   logic               clr_flags;
   int                 total = 0;
   int                 bad = 0;

   fir_out_stage_if #(.OUT_W(16)) bus ();

   fir_out_stage #(
      .ACC_W   (38),
      .OUT_W   (16),
      .DEPTH   (4),
      .SHIFT_W (5)
   ) dut (
      .clk2      (clk2),
      .rstn      (rstn),
      .acc_in    (acc_in),
      .acc_valid (acc_valid),
      .shift     (shift),
      .dn        (bus.master),
      .level     (level),
      .sat_flag  (sat_flag),
      .drop_cnt  (drop_cnt),
      .clr_flags (clr_flags)
   );

   always #5 clk2 = ~clk2;

   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   // Exact rational value: round half up of a / 2^s, s clamped to 22
   function automatic longint ref_r(longint a, int sh);
      int     s;
      longint h;
      s = (sh > 22) ? 22 : sh;
      h = (s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0;
      return (a + h) >>> s;
   endfunction

   function automatic logic [15:0] ref_clip(longint r);
      if (r > 32767) return 16'h7fff;
      if (r < -32768) return 16'h8000;
      return 16'(r);
   endfunction

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid);
      end
      total++;
      if (bus.out_data !== 16'd0) begin
         bad++; $display("FAIL rst_data got=%h want=0", bus.out_data);
      end
      total++;
      if (level !== 3'd0) begin
         bad++; $display("FAIL rst_level got=%0d want=0", level);
      end
      total++;
      if (sat_flag !== 1'b0 || drop_cnt !== 8'd0) begin
         bad++; $display("FAIL rst_flags got=%b/%0d want=0/0", sat_flag, drop_cnt);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_passthrough();
      shift = 5'd0;
      bus.out_ready = 1'b1;
      acc_in = 38'sd1000;
      acc_valid = 1'b1;
      tick();
      acc_valid = 1'b0;
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL pass_early got=%b want=0", bus.out_valid);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd1000 || level !== 3'd1) begin
         bad++;
         $display("FAIL pass_n3 got=%b/%0d/%0d want=1/1000/1", bus.out_valid, bus.out_data, level);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
         bad++; $display("FAIL pass_n4 got=%b/%0d want=0/0", bus.out_valid, level);
      end
   endtask

   task automatic test_rounding();
      int          av [4] = '{5, -5, -24, 23};
      int          sv [4] = '{1, 1, 4, 4};
      logic [15:0] ev [4] = '{16'd3, 16'hfffe, 16'hffff, 16'd1};
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         acc_in = av[i];
         shift = 5'(sv[i]);
         acc_valid = 1'b1;
         tick();
      end
      acc_valid = 1'b0;
      shift = 5'd0;
      repeat (2) tick();
      total++;
      if (level !== 3'd4) begin
         bad++; $display("FAIL round_level got=%0d want=4", level);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== ev[i]) begin
            bad++; $display("FAIL round_%0d got=%h want=%h", i, bus.out_data, ev[i]);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      bus.out_ready = 1'b0;
      shift = 5'd0;
      acc_in = 38'sd1 <<< 20;
      acc_valid = 1'b1;
      tick();
      acc_in = -(38'sd1 <<< 20);
      tick();
      acc_valid = 1'b0;
      repeat (2) tick();
      total++;
      if (sat_flag !== 1'b1 || level !== 3'd2) begin
         bad++; $display("FAIL sat_set got=%b/%0d want=1/2", sat_flag, level);
      end
      bus.out_ready = 1'b1;
      total++;
      if (bus.out_data !== 16'h7fff) begin
         bad++; $display("FAIL sat_pos got=%h want=7fff", bus.out_data);
      end
      tick();
      total++;
      if (bus.out_data !== 16'h8000) begin
         bad++; $display("FAIL sat_neg got=%h want=8000", bus.out_data);
      end
      tick();
      pulse_clr();
      total++;
      if (sat_flag !== 1'b0) begin
         bad++; $display("FAIL sat_clr got=%b want=0", sat_flag);
      end
      acc_in = 38'sd1 <<< 20;
      acc_valid = 1'b1;
      tick();
      acc_valid = 1'b0;
      pulse_clr();
      total++;
      if (sat_flag !== 1'b1) begin
         bad++; $display("FAIL sat_race got=%b want=1", sat_flag);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7fff) begin
         bad++; $display("FAIL sat_race_data got=%h want=7fff", bus.out_data);
      end
      tick();
      pulse_clr();
   endtask

   task automatic test_shift_clamp();
      logic [15:0] ev [4] = '{16'h8000, 16'h7fff, 16'h8000, 16'h7fff};
      bus.out_ready = 1'b0;
      acc_in = '0;
      acc_in[37] = 1'b1;
      shift = 5'd31;
      acc_valid = 1'b1;
      tick();
      shift = 5'd0;
      acc_in = 38'sd32767;
      tick();
      acc_in = -38'sd32768;
      tick();
      acc_valid = 1'b0;
      repeat (2) tick();
      total++;
      if (sat_flag !== 1'b0 || level !== 3'd3) begin
         bad++; $display("FAIL edge_nosat got=%b/%0d want=0/3", sat_flag, level);
      end
      acc_in = '1;
      acc_in[37] = 1'b0;
      shift = 5'd31;
      acc_valid = 1'b1;
      tick();
      acc_valid = 1'b0;
      shift = 5'd0;
      repeat (3) tick();
      total++;
      if (sat_flag !== 1'b1 || level !== 3'd4) begin
         bad++; $display("FAIL edge_sat got=%b/%0d want=1/4", sat_flag, level);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== ev[i]) begin
            bad++; $display("FAIL edge_%0d got=%h want=%h", i, bus.out_data, ev[i]);
         end
         tick();
      end
      pulse_clr();
   endtask

   task automatic test_overflow();
      bus.out_ready = 1'b0;
      shift = 5'd0;
      for (int i = 1; i <= 6; i++) begin
         acc_in = i;
         acc_valid = 1'b1;
         tick();
      end
      acc_valid = 1'b0;
      repeat (3) tick();
      total++;
      if (level !== 3'd4 || drop_cnt !== 8'd2) begin
         bad++; $display("FAIL ovf_stat got=%0d/%0d want=4/2", level, drop_cnt);
      end
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(i)) begin
            bad++; $display("FAIL ovf_data%0d got=%0d want=%0d", i, bus.out_data, i);
         end
         tick();
      end
      total++;
      if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
         bad++; $display("FAIL ovf_empty got=%b/%0d want=0/0", bus.out_valid, level);
      end
   endtask

   task automatic test_full_pop();
      pulse_clr();
      bus.out_ready = 1'b0;
      for (int i = 10; i <= 13; i++) begin
         acc_in = i;
         acc_valid = 1'b1;
         tick();
      end
      acc_valid = 1'b0;
      repeat (3) tick();
      acc_in = 38'sd14;
      acc_valid = 1'b1;
      tick();
      acc_valid = 1'b0;
      tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      total++;
      if (level !== 3'd4 || drop_cnt !== 8'd0) begin
         bad++; $display("FAIL fullpop got=%0d/%0d want=4/0", level, drop_cnt);
      end
      bus.out_ready = 1'b1;
      for (int i = 11; i <= 14; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(i)) begin
            bad++; $display("FAIL fullpop_%0d got=%0d want=%0d", i, bus.out_data, i);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [15:0] q [$];
      logic        p1v = 1'b0, p2v = 1'b0, p1s = 1'b0;
      logic [15:0] p1d = '0, p2d = '0;
      logic [15:0] mlast = 16'd14;
      logic        msat = 1'b0;
      int          mdrop = 0;
      logic [63:0] rw;
      longint      r;
      logic        pop;
      pulse_clr();
      for (int i = 0; i < 420; i++) begin
         rw = {$urandom, $urandom};
         if (rw[63]) acc_in = rw[37:0];
         else acc_in = 38'($signed(rw[23:0]));
         shift = 5'($urandom_range(0, 31));
         acc_valid = (i < 400) && ($urandom_range(0, 3) != 0);
         if (i >= 400) bus.out_ready = 1'b1;
         else if (i < 200) bus.out_ready = ($urandom_range(0, 3) == 0);
         else bus.out_ready = ($urandom_range(0, 3) != 0);
         if (q.size() > 0) mlast = q[0];
         total++;
         if (bus.out_valid !== (q.size() > 0) || level !== 3'(q.size())
             || bus.out_data !== mlast) begin
            bad++;
            $display("FAIL rnd_out cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", i,
                     bus.out_valid, level, bus.out_data, q.size() > 0, q.size(), mlast);
         end
         total++;
         if (sat_flag !== msat || drop_cnt !== 8'(mdrop)) begin
            bad++;
            $display("FAIL rnd_stat cyc=%0d got=%b/%0d want=%b/%0d", i,
                     sat_flag, drop_cnt, msat, mdrop);
         end
         pop = (q.size() > 0) && bus.out_ready;
         if (pop) void'(q.pop_front());
         if (p2v) begin
            if (q.size() < 4) q.push_back(p2d);
            else if (mdrop < 255) mdrop++;
         end
         if (p1v && p1s) msat = 1'b1;
         p2v = p1v;
         p2d = p1d;
         r = ref_r(longint'(acc_in), int'(shift));
         p1v = acc_valid;
         p1d = ref_clip(r);
         p1s = (r > 32767) || (r < -32768);
         tick();
      end
      acc_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      pulse_clr();
      bus.out_ready = 1'b0;
      shift = 5'd0;
      acc_in = 38'sd1 <<< 20;
      acc_valid = 1'b1;
      tick();
      acc_in = 38'sd5;
      tick();
      acc_in = 38'sd6;
      tick();
      acc_valid = 1'b0;
      repeat (3) tick();
      total++;
      if (level !== 3'd3 || sat_flag !== 1'b1) begin
         bad++; $display("FAIL mid_pre got=%0d/%b want=3/1", level, sat_flag);
      end
      acc_in = 38'sd7;
      acc_valid = 1'b1;
      tick();
      acc_in = 38'sd8;
      tick();
      acc_valid = 1'b0;
      rstn = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || level !== 3'd0 || bus.out_data !== 16'd0
          || sat_flag !== 1'b0 || drop_cnt !== 8'd0) begin
         bad++;
         $display("FAIL mid_rst got=%b/%0d/%h/%b/%0d want=0/0/0/0/0",
                  bus.out_valid, level, bus.out_data, sat_flag, drop_cnt);
      end
      tick();
      rstn = 1'b1;
      bus.out_ready = 1'b1;
      acc_in = 38'sd77;
      acc_valid = 1'b1;
      tick();
      acc_valid = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         total++;
         if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_stale%0d got=%b want=0", i, bus.out_valid);
         end
         tick();
      end
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd77 || level !== 3'd1) begin
         bad++;
         $display("FAIL mid_post got=%b/%0d/%0d want=1/77/1", bus.out_valid, bus.out_data, level);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
         bad++; $display("FAIL mid_alone got=%b/%0d want=0/0", bus.out_valid, level);
      end
   endtask

   initial begin
      rstn = 1'b0;
      acc_in = '0;
      acc_valid = 1'b0;
      shift = '0;
      clr_flags = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_passthrough();
      test_rounding();
      test_saturation();
      test_shift_clamp();
      test_overflow();
      test_full_pop();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
